// File: rtl/cpu_defs.sv
// Shared definitions for the MEM stage: bus widths, bus layouts and field indices.
package cpu_defs;

  localparam int PASS_W   = 141;
  localparam int EM_W     = PASS_W + 76;
  localparam int WB_BUS_W = 211;
  localparam int ID_BUS_W = 39;

  // Bit positions inside the sideband field. The exception flag travels as the
  // lowest sideband bit, so the EX bus is exactly PASS_W+76 bits wide.
  localparam int PASS_EXC_BIT  = 0;
  localparam int PASS_ERTN_BIT = 1;

  // load_op is one-hot {ld_b, ld_bu, ld_h, ld_hu, ld_w}
  localparam int LD_W  = 0;
  localparam int LD_HU = 1;
  localparam int LD_H  = 2;
  localparam int LD_BU = 3;
  localparam int LD_B  = 4;

  typedef struct packed {
    logic [PASS_W-1:0] pass;
    logic [4:0]        load_op;
    logic              req_issued;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [31:0]       alu_result;
    logic [31:0]       pc;
  } ex_bus_t;

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half/word of a load response and sign- or zero-extends it.
module load_extend
  import cpu_defs::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  sel,
  input  logic [4:0]  load_op,
  output logic [31:0] wdata
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // Byte lane picked by the low address bits
  always_comb begin
    byte_val = rdata[7:0];
    case (sel)
      2'd0: byte_val = rdata[7:0];
      2'd1: byte_val = rdata[15:8];
      2'd2: byte_val = rdata[23:16];
      2'd3: byte_val = rdata[31:24];
      default: byte_val = rdata[7:0];
    endcase
  end

  assign half_val = sel[1] ? rdata[31:16] : rdata[15:0];

  // Extension according to the one-hot load kind
  always_comb begin
    wdata = '0;
    if (load_op[LD_B])       wdata = {{24{byte_val[7]}}, byte_val};
    else if (load_op[LD_BU]) wdata = {24'd0, byte_val};
    else if (load_op[LD_H])  wdata = {{16{half_val[15]}}, half_val};
    else if (load_op[LD_HU]) wdata = {16'd0, half_val};
    else if (load_op[LD_W])  wdata = rdata;
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction from EX, waits for its data-SRAM
// response, extends load data, forwards to ID and hands the result to WB.
module mem_stage
  import cpu_defs::*;
(
  input  logic                clk,
  input  logic                resetn,
  output logic                mem_allowin,
  input  logic                ex_to_mem_valid,
  input  logic [EM_W-1:0]     ex_to_mem_bus,
  input  logic                wb_allowin,
  output logic                mem_to_wb_valid,
  output logic [WB_BUS_W-1:0] mem_to_wb_bus,
  output logic [ID_BUS_W-1:0] mem_to_id_bus,
  output logic                mem_to_ex_bus,
  input  logic                data_sram_data_ok,
  input  logic [31:0]         data_sram_rdata,
  input  logic                flush
);

  ex_bus_t     ex_in;
  ex_bus_t     inst;
  logic        mem_valid;
  logic        wait_resp;
  logic [31:0] rdata_buf;
  logic [1:0]  discard_cnt;

  logic        resp_live;
  logic        ready_go;
  logic        accept;
  logic        discard_inc;
  logic        discard_dec;
  logic        exc;
  logic        ertn;
  logic        is_load;
  logic [31:0] ld_data;
  logic [31:0] ld_wdata;
  logic [31:0] rf_wdata;

  assign ex_in = ex_to_mem_bus;

  // A response belongs to the current instruction only once all stale ones are drained
  assign resp_live   = data_sram_data_ok & (discard_cnt == 2'd0);
  assign ready_go    = ~wait_resp | resp_live;
  assign mem_allowin = ~mem_valid | (ready_go & wb_allowin);
  assign accept      = ex_to_mem_valid & mem_allowin;

  // A flushed instruction that still has a response in flight leaves one stale response
  // behind; a stale response arriving in the same cycle retires an older one.
  assign discard_inc = flush & mem_valid & wait_resp & ~resp_live;
  assign discard_dec = data_sram_data_ok & (discard_cnt != 2'd0);

  // Stage occupancy; flush from WB overrides everything
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)          mem_valid <= 1'b0;
    else if (flush)       mem_valid <= 1'b0;
    else if (mem_allowin) mem_valid <= ex_to_mem_valid;
  end

  // Instruction fields captured on the EX handshake
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     inst <= '0;
    else if (accept) inst <= ex_in;
  end

  // Outstanding-response flag for the instruction in MEM
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                     wait_resp <= 1'b0;
    else if (flush)                  wait_resp <= 1'b0;
    else if (accept)                 wait_resp <= ex_in.req_issued & ~ex_in.pass[PASS_EXC_BIT];
    else if (mem_valid & resp_live)  wait_resp <= 1'b0;
  end

  // Response data held while WB stalls
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                rdata_buf <= '0;
    else if (mem_valid & wait_resp & resp_live) rdata_buf <= data_sram_rdata;
  end

  // Number of stale responses still to be dropped
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                          discard_cnt <= 2'd0;
    else if (discard_inc & ~discard_dec)  discard_cnt <= discard_cnt + 2'd1;
    else if (discard_dec & ~discard_inc)  discard_cnt <= discard_cnt - 2'd1;
  end

  // In the response cycle the SRAM data bypasses the buffer
  assign ld_data = wait_resp ? data_sram_rdata : rdata_buf;

  load_extend u_load_extend (
    .rdata   (ld_data),
    .sel     (inst.alu_result[1:0]),
    .load_op (inst.load_op),
    .wdata   (ld_wdata)
  );

  assign exc      = inst.pass[PASS_EXC_BIT];
  assign ertn     = inst.pass[PASS_ERTN_BIT];
  assign is_load  = |inst.load_op;
  assign rf_wdata = is_load ? ld_wdata : inst.alu_result;

  assign mem_to_wb_valid = mem_valid & ready_go;
  assign mem_to_wb_bus   = {inst.rf_we, inst.rf_waddr, rf_wdata, inst.pc, inst.pass};
  assign mem_to_id_bus   = {mem_valid & inst.rf_we & ~exc, inst.rf_waddr, rf_wdata,
                            mem_valid & is_load & ~ready_go};
  assign mem_to_ex_bus   = mem_valid & (exc | ertn);

endmodule
